clock_set_ctrl: RTL

User-interface controller for the 24-hour hh:mm:ss timekeeper. It sequences set-time and set-alarm modes from two pulse buttons and issues a one-cycle load strobe with new hr/min values to the timekeeper. It also holds the alarm time, compares it against the running time, and drives a timed ring output. It sits between the debounced button logic and the timekeeper/display.

---
 rtl/clock_set_ctrl_if.sv | 38 +++
 rtl/clock_set_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl_if.sv
// Bus between the button/timekeeper side and the clock set controller.
// The controller connects through the slave modport; the driver of buttons,
// running time and the consumer of load/display/ring use the master modport.
interface clock_set_ctrl_if;
    // Buttons and arm switch
    logic       mode_btn;
    logic       inc_btn;
    logic       alarm_en;
    // Running time from the timekeeper
    logic [5:0] cur_sec;
    logic [5:0] cur_min;
    logic [4:0] cur_hr;
    // Load strobe and values back to the timekeeper
    logic       load;
    logic [4:0] load_hr;
    logic [5:0] load_min;
    logic [5:0] load_sec;
    // Status, display and alarm outputs
    logic [2:0] mode;
    logic [4:0] disp_hr;
    logic [5:0] disp_min;
    logic       blink;
    logic [4:0] alm_hr;
    logic [5:0] alm_min;
    logic       ring;

    modport slave (
        input  mode_btn, inc_btn, alarm_en, cur_sec, cur_min, cur_hr,
        output load, load_hr, load_min, load_sec, mode, disp_hr, disp_min,
               blink, alm_hr, alm_min, ring
    );

    modport master (
        output mode_btn, inc_btn, alarm_en, cur_sec, cur_min, cur_hr,
        input  load, load_hr, load_min, load_sec, mode, disp_hr, disp_min,
               blink, alm_hr, alm_min, ring
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Set-time / set-alarm controller for a 24-hour hh:mm:ss timekeeper.
// Sequences edit modes from two pulse buttons, issues a one-cycle load of
// the edited hr/min, holds the alarm time and drives a timed ring output.
module clock_set_ctrl #(
    parameter int TICK_DIV  = 10,   // clk cycles per second, even and >= 2
    parameter int RING_SECS = 30    // ring duration in seconds, 1..63
) (
    input  logic              clk,
    input  logic              rst,
    clock_set_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_SET_HR  = 3'd1,
        ST_SET_MIN = 3'd2,
        ST_ALM_HR  = 3'd3,
        ST_ALM_MIN = 3'd4
    } state_e;

    // One counter width serves both dividers: blink_div only needs half the range.
    localparam int               DIV_W      = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] SEC_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] BLINK_LAST = DIV_W'(TICK_DIV / 2 - 1);
    localparam logic [5:0]       RING_INIT  = 6'(RING_SECS);

    state_e           state_q, state_d;
    logic [4:0]       edit_hr_q, edit_hr_d;
    logic [5:0]       edit_min_q, edit_min_d;
    logic [4:0]       alm_hr_q, alm_hr_d;
    logic [5:0]       alm_min_q, alm_min_d;
    logic             load_q, load_d;
    logic [4:0]       load_hr_q, load_hr_d;
    logic [5:0]       load_min_q, load_min_d;
    logic             ring_q, ring_d;
    logic [5:0]       ring_cnt_q, ring_cnt_d;
    logic [DIV_W-1:0] sec_div_q, sec_div_d;
    logic             blink_q, blink_d;
    logic [DIV_W-1:0] blink_div_q, blink_div_d;
    logic             armed_q, armed_d;

    logic             sec_wrap;
    logic             match;
    logic             dismiss;

    function automatic logic [4:0] inc_hr(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [5:0] inc_min(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    // Mode sequencing, field edits and the load strobe; mode_btn wins over inc_btn.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d    = state_q;
        edit_hr_d  = edit_hr_q;
        edit_min_d = edit_min_q;
        alm_hr_d   = alm_hr_q;
        alm_min_d  = alm_min_q;
        load_d     = 1'b0;
        load_hr_d  = load_hr_q;
        load_min_d = load_min_q;

        case (state_q)
            ST_RUN: begin
                // inc_btn in RUN only dismisses the ring (handled below).
                if (bus.mode_btn) begin
                    state_d    = ST_SET_HR;
                    edit_hr_d  = bus.cur_hr;
                    edit_min_d = bus.cur_min;
                end
            end
            ST_SET_HR: begin
                if (bus.mode_btn)     state_d   = ST_SET_MIN;
                else if (bus.inc_btn) edit_hr_d = inc_hr(edit_hr_q);
            end
            ST_SET_MIN: begin
                if (bus.mode_btn) begin
                    state_d    = ST_ALM_HR;
                    load_d     = 1'b1;
                    load_hr_d  = edit_hr_q;
                    load_min_d = edit_min_q;
                end else if (bus.inc_btn) begin
                    edit_min_d = inc_min(edit_min_q);
                end
            end
            ST_ALM_HR: begin
                if (bus.mode_btn)     state_d  = ST_ALM_MIN;
                else if (bus.inc_btn) alm_hr_d = inc_hr(alm_hr_q);
            end
            ST_ALM_MIN: begin
                if (bus.mode_btn)     state_d   = ST_RUN;
                else if (bus.inc_btn) alm_min_d = inc_min(alm_min_q);
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Blink divider: idle in RUN, restarted on every mode change, toggles on wrap.
    always_comb begin
        blink_d     = blink_q;
        blink_div_d = blink_div_q;
        if (state_q == ST_RUN || state_d != state_q) begin
            blink_d     = 1'b0;
            blink_div_d = '0;
        end else if (blink_div_q == BLINK_LAST) begin
            blink_d     = ~blink_q;
            blink_div_d = '0;
        end else begin
            blink_div_d = blink_div_q + 1'b1;
        end
    end

    assign sec_wrap = (sec_div_q == SEC_LAST);
    assign match    = (state_q == ST_RUN) && bus.alarm_en && armed_q &&
                      (bus.cur_hr == alm_hr_q) && (bus.cur_min == alm_min_q) &&
                      (bus.cur_sec == 6'd0);
    assign dismiss  = ring_q && (bus.mode_btn || !bus.alarm_en ||
                      (state_q == ST_RUN && bus.inc_btn));

    // Alarm arming, second divider and ring countdown; a dismiss overrides a match.
    always_comb begin
        sec_div_d  = sec_wrap ? '0 : sec_div_q + 1'b1;
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        armed_d    = armed_q;

        // Leaving the alarm minute re-arms, so a held match fires only once.
        if (bus.cur_min != alm_min_q) armed_d = 1'b1;

        if (ring_q && sec_wrap) begin
            ring_cnt_d = ring_cnt_q - 6'd1;
            if (ring_cnt_q == 6'd1) ring_d = 1'b0;
        end

        // Restarting sec_div makes the ring exactly RING_SECS whole seconds long.
        if (match) begin
            ring_d     = 1'b1;
            ring_cnt_d = RING_INIT;
            armed_d    = 1'b0;
            sec_div_d  = '0;
        end

        if (dismiss) begin
            ring_d     = 1'b0;
            ring_cnt_d = 6'd0;
        end
    end

    // State register with synchronous reset; edits in flight are discarded.
    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignments so every register samples
        // the pre-edge value of the others, independent of statement order.
        if (rst) begin
            state_q     <= ST_RUN;
            edit_hr_q   <= '0;
            edit_min_q  <= '0;
            alm_hr_q    <= '0;
            alm_min_q   <= '0;
            load_q      <= 1'b0;
            load_hr_q   <= '0;
            load_min_q  <= '0;
            ring_q      <= 1'b0;
            ring_cnt_q  <= '0;
            sec_div_q   <= '0;
            blink_q     <= 1'b0;
            blink_div_q <= '0;
            armed_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            edit_hr_q   <= edit_hr_d;
            edit_min_q  <= edit_min_d;
            alm_hr_q    <= alm_hr_d;
            alm_min_q   <= alm_min_d;
            load_q      <= load_d;
            load_hr_q   <= load_hr_d;
            load_min_q  <= load_min_d;
            ring_q      <= ring_d;
            ring_cnt_q  <= ring_cnt_d;
            sec_div_q   <= sec_div_d;
            blink_q     <= blink_d;
            blink_div_q <= blink_div_d;
            armed_q     <= armed_d;
        end
    end

    // Display mux: running time in RUN, edit buffer in SET_*, alarm in ALM_*.
    always_comb begin
        bus.disp_hr  = bus.cur_hr;
        bus.disp_min = bus.cur_min;
        case (state_q)
            ST_SET_HR, ST_SET_MIN: begin
                bus.disp_hr  = edit_hr_q;
                bus.disp_min = edit_min_q;
            end
            ST_ALM_HR, ST_ALM_MIN: begin
                bus.disp_hr  = alm_hr_q;
                bus.disp_min = alm_min_q;
            end
            default: ;
        endcase
    end

    assign bus.load     = load_q;
    assign bus.load_hr  = load_hr_q;
    assign bus.load_min = load_min_q;
    assign bus.load_sec = 6'd0;
    assign bus.mode     = state_q;
    assign bus.blink    = blink_q;
    assign bus.alm_hr   = alm_hr_q;
    assign bus.alm_min  = alm_min_q;
    assign bus.ring     = ring_q;

endmodule
